// File: rtl/vregs_pkg.sv
// vregs_pkg: default sizes, width helpers and clear-sequencer state type for the vector register file.
package vregs_pkg;
    localparam int VREG_NREGS = 16;
    localparam int VREG_NELEM = 16;
    localparam int VREG_EW    = 16;

    function automatic int awOf(input int nRegs);
        return $clog2(nRegs);
    endfunction

    function automatic int iwOf(input int nElem);
        return $clog2(nElem);
    endfunction

    // Length counts 0..NELEM inclusive, so it needs one more code than an index.
    function automatic int lwOf(input int nElem);
        return $clog2(nElem + 1);
    endfunction

    typedef enum logic {CLR_IDLE, CLR_CLEAR} clr_state_t;
endpackage

// File: rtl/vregs_if.sv
// vregs_if: read, write and clear-request signals of the vector register file.
interface vregs_if import vregs_pkg::*; #(
    parameter int NREGS = VREG_NREGS,
    parameter int NELEM = VREG_NELEM,
    parameter int EW    = VREG_EW
);
    localparam int AW = awOf(NREGS);
    localparam int IW = iwOf(NELEM);
    localparam int LW = lwOf(NELEM);

    logic                  clr_req;
    logic                  ready;
    logic [AW-1:0]         rAddr0;
    logic [NELEM*EW-1:0]   rData0;
    logic [LW-1:0]         rLen0;
    logic [AW-1:0]         rAddr1;
    logic [NELEM*EW-1:0]   rData1;
    logic [LW-1:0]         rLen1;
    logic [AW-1:0]         rAddr2;
    logic [IW-1:0]         rInd2;
    logic [EW-1:0]         rData2;
    logic                  wEn;
    logic [AW-1:0]         wAddr;
    logic [IW-1:0]         wInd;
    logic [EW-1:0]         wData;
    logic                  vwEn;
    logic [AW-1:0]         vwAddr;
    logic [NELEM-1:0]      vwMask;
    logic [NELEM*EW-1:0]   vwData;
    logic [LW-1:0]         vwLen;

    modport master (
        output clr_req, rAddr0, rAddr1, rAddr2, rInd2,
        output wEn, wAddr, wInd, wData, vwEn, vwAddr, vwMask, vwData, vwLen,
        input  ready, rData0, rLen0, rData1, rLen1, rData2
    );

    modport slave (
        input  clr_req, rAddr0, rAddr1, rAddr2, rInd2,
        input  wEn, wAddr, wInd, wData, vwEn, vwAddr, vwMask, vwData, vwLen,
        output ready, rData0, rLen0, rData1, rLen1, rData2
    );
endinterface

// File: rtl/vregs_clear_fsm.sv
// vregs_clear_fsm: walks every register once after reset or a clear request, one per cycle.
module vregs_clear_fsm import vregs_pkg::*; #(
    parameter int NREGS = VREG_NREGS,
    localparam int AW = awOf(NREGS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_req,
    output logic          ready,
    output logic          clr_active,
    output logic [AW-1:0] clr_addr
);
    clr_state_t state;
    logic [AW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= CLR_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end else if (state == CLR_CLEAR) begin
            if (cnt == AW'(NREGS - 1)) begin
                state <= CLR_IDLE;
                ready <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else if (clr_req) begin
            state <= CLR_CLEAR;
            cnt   <= '0;
            ready <= 1'b0;
        end
    end

    assign clr_active = (state == CLR_CLEAR);
    assign clr_addr   = cnt;
endmodule

// File: rtl/vregs_param.sv
// vregs_param: NREGS x NELEM x EW vector register file with per-register length,
// three read ports, element and masked vector write ports, and a self-clearing sequencer.
module vregs_param import vregs_pkg::*; #(
    parameter int NREGS = VREG_NREGS,
    parameter int NELEM = VREG_NELEM,
    parameter int EW    = VREG_EW
) (
    input logic    clk,
    input logic    rst,
    vregs_if.slave bus
);
    localparam int AW = awOf(NREGS);
    localparam int LW = lwOf(NELEM);

    logic [NELEM*EW-1:0] mem [NREGS];
    logic [LW-1:0]       len [NREGS];
    logic                ready;
    logic                clrActive;
    logic [AW-1:0]       clrAddr;
    logic [NELEM*EW-1:0] vwBits;
    logic [NELEM*EW-1:0] vwMerged;
    logic [LW-1:0]       satLen;

    vregs_clear_fsm #(.NREGS(NREGS)) uClear (
        .clk        (clk),
        .rst        (rst),
        .clr_req    (bus.clr_req),
        .ready      (ready),
        .clr_active (clrActive),
        .clr_addr   (clrAddr)
    );

    always_comb begin
        vwBits = '0;
        for (int i = 0; i < NELEM; i++)
            vwBits[i*EW +: EW] = {EW{bus.vwMask[i]}};
        vwMerged = (mem[bus.vwAddr] & ~vwBits) | (bus.vwData & vwBits);
    end

    assign satLen = (bus.vwLen > LW'(NELEM)) ? LW'(NELEM) : bus.vwLen;

    // The element write follows the vector write so it wins on a shared element.
    always_ff @(posedge clk) begin
        if (clrActive) begin
            mem[clrAddr] <= '0;
            len[clrAddr] <= '0;
        end else if (ready) begin
            if (bus.vwEn) begin
                mem[bus.vwAddr] <= vwMerged;
                len[bus.vwAddr] <= satLen;
            end
            if (bus.wEn)
                mem[bus.wAddr][bus.wInd*EW +: EW] <= bus.wData;
        end
    end

    assign bus.ready  = ready;
    assign bus.rData0 = ready ? mem[bus.rAddr0] : '0;
    assign bus.rLen0  = ready ? len[bus.rAddr0] : '0;
    assign bus.rData1 = ready ? mem[bus.rAddr1] : '0;
    assign bus.rLen1  = ready ? len[bus.rAddr1] : '0;
    assign bus.rData2 = ready ? mem[bus.rAddr2][bus.rInd2*EW +: EW] : '0;
endmodule

// File: tb/tb_vregs_param.sv
// tb_vregs_param: table vectors, hand sequences and randomized traffic against a behavioural model.
module tb_vregs_param;
    import vregs_pkg::*;
    localparam int N  = VREG_NREGS;
    localparam int E  = VREG_NELEM;
    localparam int W  = VREG_EW;
    localparam int AW = awOf(N);
    localparam int IW = iwOf(E);
    localparam int LW = lwOf(E);

    typedef logic [E*W-1:0] vec_t;
    typedef struct {
        logic        wEn;
        int          wAddr;
        int          wInd;
        logic [W-1:0] wData;
        logic        vwEn;
        int          vwAddr;
        logic [E-1:0] vwMask;
        logic [W-1:0] fill;
        int          vwLen;
        int          rdAddr;
        int          rdInd;
        logic [W-1:0] expElem;
        int          expLen;
    } row_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    logic [W-1:0] mMem [N][E];
    int mLen [N];
    bit mReady = 1'b0;
    bit mClr = 1'b0;
    int mCnt = 0;

    vregs_if #(.NREGS(N), .NELEM(E), .EW(W)) bus ();
    vregs_param #(.NREGS(N), .NELEM(E), .EW(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input vec_t act, input vec_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        bus.clr_req = 1'b0;
        bus.rAddr0 = '0;
        bus.rAddr1 = '0;
        bus.rAddr2 = '0;
        bus.rInd2 = '0;
        bus.wEn = 1'b0;
        bus.wAddr = '0;
        bus.wInd = '0;
        bus.wData = '0;
        bus.vwEn = 1'b0;
        bus.vwAddr = '0;
        bus.vwMask = '0;
        bus.vwData = '0;
        bus.vwLen = '0;
    endtask

    // Applies the effect of the coming rising edge to the model, then lets it happen.
    task automatic cycle();
        bit wasReady;
        wasReady = mReady;
        if (rst) begin
            mClr = 1'b1;
            mCnt = 0;
            mReady = 1'b0;
        end else begin
            if (wasReady && bus.vwEn) begin
                for (int e = 0; e < E; e++)
                    if (bus.vwMask[e]) mMem[bus.vwAddr][e] = bus.vwData[e*W +: W];
                mLen[bus.vwAddr] = (int'(bus.vwLen) > E) ? E : int'(bus.vwLen);
            end
            if (wasReady && bus.wEn) mMem[bus.wAddr][bus.wInd] = bus.wData;
            if (mClr) begin
                for (int e = 0; e < E; e++) mMem[mCnt][e] = '0;
                mLen[mCnt] = 0;
                mCnt++;
                if (mCnt == N) begin
                    mClr = 1'b0;
                    mReady = 1'b1;
                end
            end else if (bus.clr_req) begin
                mClr = 1'b1;
                mCnt = 0;
                mReady = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkAll(input string tag);
        vec_t e0, e1;
        e0 = '0;
        e1 = '0;
        for (int e = 0; e < E; e++) begin
            e0[e*W +: W] = mMem[bus.rAddr0][e];
            e1[e*W +: W] = mMem[bus.rAddr1][e];
        end
        chk({tag, ".ready"}, vec_t'(bus.ready), vec_t'(mReady));
        chk({tag, ".rData0"}, bus.rData0, mReady ? e0 : '0);
        chk({tag, ".rLen0"}, vec_t'(bus.rLen0), mReady ? vec_t'(mLen[bus.rAddr0]) : '0);
        chk({tag, ".rData1"}, bus.rData1, mReady ? e1 : '0);
        chk({tag, ".rLen1"}, vec_t'(bus.rLen1), mReady ? vec_t'(mLen[bus.rAddr1]) : '0);
        chk({tag, ".rData2"}, vec_t'(bus.rData2), mReady ? vec_t'(mMem[bus.rAddr2][bus.rInd2]) : '0);
    endtask

    task automatic waitReady(output int n);
        n = 0;
        while (!bus.ready && n < 100) begin
            cycle();
            n++;
        end
    endtask

    row_t tbl [8];

    initial begin
        int n;
        for (int r = 0; r < N; r++) begin
            mLen[r] = 0;
            for (int e = 0; e < E; e++) mMem[r][e] = '0;
        end
        idleInputs();

        tbl[0] = '{1'b0, 0, 0, 16'h0000, 1'b1, 7, 16'h00F0, 16'h1111, 20, 7, 4, 16'h1111, 16};
        tbl[1] = '{1'b0, 0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 0, 7, 3, 16'h0000, 16};
        tbl[2] = '{1'b0, 0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 0, 7, 7, 16'h1111, 16};
        tbl[3] = '{1'b1, 2, 0, 16'hAAAA, 1'b1, 2, 16'h0003, 16'h5555, 3, 2, 0, 16'hAAAA, 3};
        tbl[4] = '{1'b0, 0, 0, 16'h0000, 1'b0, 0, 16'h0000, 16'h0000, 0, 2, 1, 16'h5555, 3};
        tbl[5] = '{1'b0, 0, 0, 16'h0000, 1'b1, 5, 16'h0000, 16'h9999, 9, 5, 0, 16'h0000, 9};
        tbl[6] = '{1'b0, 0, 0, 16'h0000, 1'b1, 5, 16'hFFFF, 16'h1234, 16, 5, 15, 16'h1234, 16};
        tbl[7] = '{1'b1, 5, 15, 16'hCAFE, 1'b1, 5, 16'h7FFF, 16'h7777, 2, 5, 15, 16'hCAFE, 2};

        // Reset and initial clear timing.
        repeat (3) cycle();
        checkAll("rst");
        rst = 1'b0;
        for (int k = 1; k <= N; k++) begin
            cycle();
            chk($sformatf("clrTiming%0d", k), vec_t'(bus.ready), vec_t'(k == N));
        end
        for (int r = 0; r < N; r++) begin
            bus.rAddr0 = AW'(r);
            bus.rAddr1 = AW'(N - 1 - r);
            #1;
            chk($sformatf("postClrLen%0d", r), vec_t'(bus.rLen0), '0);
            checkAll("postClr");
        end

        // Element write, then read the next cycle.
        bus.wEn = 1'b1;
        bus.wAddr = AW'(3);
        bus.wInd = IW'(5);
        bus.wData = 16'hBEEF;
        bus.rAddr2 = AW'(3);
        bus.rInd2 = IW'(5);
        bus.rAddr0 = AW'(3);
        #1;
        chk("elemSameCycle", vec_t'(bus.rData2), '0);
        cycle();
        bus.wEn = 1'b0;
        #1;
        chk("elemNext", vec_t'(bus.rData2), vec_t'(16'hBEEF));
        chk("elemVec", vec_t'(bus.rData0[95:80]), vec_t'(16'hBEEF));
        chk("elemLen", vec_t'(bus.rLen0), '0);

        // Table-driven write/read vectors.
        for (int i = 0; i < 8; i++) begin
            bus.wEn = tbl[i].wEn;
            bus.wAddr = AW'(tbl[i].wAddr);
            bus.wInd = IW'(tbl[i].wInd);
            bus.wData = tbl[i].wData;
            bus.vwEn = tbl[i].vwEn;
            bus.vwAddr = AW'(tbl[i].vwAddr);
            bus.vwMask = tbl[i].vwMask;
            bus.vwData = {E{tbl[i].fill}};
            bus.vwLen = LW'(tbl[i].vwLen);
            cycle();
            idleInputs();
            bus.rAddr0 = AW'(tbl[i].rdAddr);
            bus.rAddr2 = AW'(tbl[i].rdAddr);
            bus.rInd2 = IW'(tbl[i].rdInd);
            #1;
            chk($sformatf("tblElem%0d", i), vec_t'(bus.rData2), vec_t'(tbl[i].expElem));
            chk($sformatf("tblLen%0d", i), vec_t'(bus.rLen0), vec_t'(tbl[i].expLen));
            checkAll($sformatf("tbl%0d", i));
        end

        // Randomized traffic with occasional clear requests.
        for (int c = 0; c < 400; c++) begin
            bus.clr_req = ($urandom_range(0, 49) == 0);
            bus.rAddr0 = AW'($urandom);
            bus.rAddr1 = AW'($urandom);
            bus.rAddr2 = AW'($urandom);
            bus.rInd2 = IW'($urandom);
            bus.wEn = 1'($urandom);
            bus.wAddr = AW'($urandom_range(0, 3));
            bus.wInd = IW'($urandom);
            bus.wData = W'($urandom);
            bus.vwEn = 1'($urandom);
            bus.vwAddr = AW'($urandom_range(0, 3));
            bus.vwMask = E'($urandom);
            for (int e = 0; e < E; e++) bus.vwData[e*W +: W] = W'($urandom);
            bus.vwLen = LW'($urandom);
            #1;
            checkAll("rand");
            cycle();
        end
        idleInputs();
        waitReady(n);
        chk("randSettle", vec_t'(bus.ready), vec_t'(1'b1));

        // Clear request, then a write during the clear that must be dropped.
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        #1;
        chk("clrAccepted", vec_t'(bus.ready), '0);
        bus.wEn = 1'b1;
        bus.wAddr = AW'(1);
        bus.wInd = '0;
        bus.wData = 16'h1234;
        cycle();
        bus.wEn = 1'b0;
        waitReady(n);
        chk("clrLength", vec_t'(n), vec_t'(N - 1));
        bus.rAddr2 = AW'(1);
        bus.rInd2 = '0;
        #1;
        chk("droppedWrite", vec_t'(bus.rData2), '0);
        checkAll("dropped");

        // Reset arriving mid-clear restarts at register 0.
        bus.clr_req = 1'b1;
        cycle();
        bus.clr_req = 1'b0;
        repeat (9) cycle();
        rst = 1'b1;
        repeat (2) cycle();
        rst = 1'b0;
        #1;
        chk("midRstReady", vec_t'(bus.ready), '0);
        waitReady(n);
        chk("midRstLength", vec_t'(n), vec_t'(N));
        checkAll("midRst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
